fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the 5-stage MIPS pipeline. Owns the PC register and drives
//  the address of the combinational instruction memory. Latches the returned word into the IF/ID

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_sequencer_if_id_reg.sv | 53 +++++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and instruction constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] JMP_SELF_INSTR = 32'hA800_FFFF;
  localparam int          PC_STEP        = 4;

endpackage

// File: rtl/fetch_sequencer_if_id_reg.sv
// IF/ID pipeline register: 1-cycle load; flush beats hold; hold freezes contents.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic [N-1:0] pc_in,
  input  logic [N-1:0] instr_in,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] instr_out,
  output logic         valid_out
);

  logic [N-1:0] pc_d, pc_q;
  logic [N-1:0] instr_d, instr_q;
  logic         valid_d, valid_q;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = N'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (!hold) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= N'(NOP_INSTR);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and IF stage controller; self-jump halt detection under FETCH_HALT_DETECT_EN.
// Latency 1 cycle imem_pc -> IF/ID; freeze holds PC and IF/ID, branch redirect flushes.
module fetch_sequencer #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic [N-1:0] imem_pc,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] if_id_pc,
  output logic [N-1:0] if_id_instr,
  output logic         if_id_valid,
  output logic         halted
);
  import fetch_pkg::*;

  fetch_state_e state_d, state_q;
  logic [N-1:0] pc_d, pc_q;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] target_aligned;
  logic         if_flush;
  logic         if_hold;
  logic         unused_target_bits;

  assign pc_plus4           = pc_q + N'(PC_STEP);
  assign target_aligned     = {branch_target[N-1:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

`ifdef FETCH_HALT_DETECT_EN
  logic halted_d, halted_q;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    if_flush = 1'b0;
    if_hold  = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      // Memory output is not yet valid on the boot cycle, so nothing is latched.
      ST_BOOT: begin
        state_d  = ST_RUN;
        if_flush = 1'b1;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_d     = target_aligned;
          if_flush = 1'b1;
        end else if (freeze) begin
          if_hold = 1'b1;
        end else begin
          pc_d = pc_plus4;
`ifdef FETCH_HALT_DETECT_EN
          if (imem_instr == N'(JMP_SELF_INSTR)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
`endif
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      // A branch here means the self-jump was on the wrong path.
      ST_HALT: begin
        if_flush = 1'b1;
        if (branch_taken) begin
          pc_d     = target_aligned;
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d  = ST_BOOT;
        if_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
`ifdef FETCH_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
`ifdef FETCH_HALT_DETECT_EN
      halted_q <= halted_d;
`endif
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign imem_pc = pc_q;

  if_id_reg #(.N(N)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (if_flush),
    .hold      (if_hold),
    .pc_in     (pc_plus4),
    .instr_in  (imem_instr),
    .pc_out    (if_id_pc),
    .instr_out (if_id_instr),
    .valid_out (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: constant vector table, directed corner sequences, random vs model.
module tb_fetch_sequencer;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [31:0] JMP = 32'hA800_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_pc, imem_instr, if_id_pc, if_id_instr;
  logic        if_id_valid, halted;
  logic [31:0] mem [64];

  assign imem_instr = mem[imem_pc[7:2]];
  always #5 clk = ~clk;

  fetch_sequencer #(.N(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = booting, 1 = running, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc = '0, m_ipc = '0, m_instr = '0;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] t);
    logic [31:0] w;
    rst = r; freeze = f; branch_taken = b; branch_target = t;
    w = mem[m_pc[7:2]];
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_ipc = '0; m_instr = '0; m_valid = 0; m_halted = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (b) begin
      m_pc = t & ~32'h3; m_ipc = '0; m_instr = '0; m_valid = 0; m_halted = 0; m_mode = 1;
    end else if (m_mode == 2) begin
      m_ipc = '0; m_instr = '0; m_valid = 0;
    end else if (!f) begin
      m_ipc = m_pc + 32'd4; m_instr = w; m_valid = 1; m_pc = m_pc + 32'd4;
      if (HALT_EN && w == JMP) begin
        m_mode = 2; m_halted = 1;
      end
    end
    @(posedge clk); #1;
    chk("model imem_pc", imem_pc, m_pc);
    chk("model if_id_pc", if_id_pc, m_ipc);
    chk("model if_id_instr", if_id_instr, m_instr);
    chk("model if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("model halted", 32'(halted), 32'(m_halted));
  endtask

  typedef struct {
    logic        r, f, b;
    logic [31:0] t, pc, ipc, instr;
    logic        v;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ipc,
                              input logic [31:0] instr, input logic v);
    vec_t x;
    x.r = r; x.f = f; x.b = b; x.t = t; x.pc = pc; x.ipc = ipc; x.instr = instr; x.v = v;
    return x;
  endfunction

  function automatic logic [31:0] mw(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  vec_t tbl [19];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = mw(i);
    mem[57] = JMP;

    tbl[0]  = mk(1, 0, 0, 0,     32'h00, 32'h00, 32'h0,  0);
    tbl[1]  = mk(1, 0, 0, 0,     32'h00, 32'h00, 32'h0,  0);
    tbl[2]  = mk(0, 0, 0, 0,     32'h00, 32'h00, 32'h0,  0);  // boot cycle
    tbl[3]  = mk(0, 0, 0, 0,     32'h04, 32'h04, mw(0),  1);
    tbl[4]  = mk(0, 0, 0, 0,     32'h08, 32'h08, mw(1),  1);
    tbl[5]  = mk(0, 0, 0, 0,     32'h0C, 32'h0C, mw(2),  1);
    tbl[6]  = mk(0, 0, 0, 0,     32'h10, 32'h10, mw(3),  1);
    tbl[7]  = mk(0, 1, 0, 0,     32'h10, 32'h10, mw(3),  1);  // freeze x3
    tbl[8]  = mk(0, 1, 0, 0,     32'h10, 32'h10, mw(3),  1);
    tbl[9]  = mk(0, 1, 0, 0,     32'h10, 32'h10, mw(3),  1);
    tbl[10] = mk(0, 0, 0, 0,     32'h14, 32'h14, mw(4),  1);
    tbl[11] = mk(0, 0, 0, 0,     32'h18, 32'h18, mw(5),  1);
    tbl[12] = mk(0, 0, 0, 0,     32'h1C, 32'h1C, mw(6),  1);
    tbl[13] = mk(0, 0, 0, 0,     32'h20, 32'h20, mw(7),  1);
    tbl[14] = mk(0, 1, 1, 32'h13, 32'h10, 32'h00, 32'h0, 0);  // branch beats freeze
    tbl[15] = mk(0, 0, 0, 0,     32'h14, 32'h14, mw(4),  1);
    tbl[16] = mk(1, 1, 0, 0,     32'h00, 32'h00, 32'h0,  0);
    tbl[17] = mk(0, 1, 1, 32'h80, 32'h00, 32'h00, 32'h0, 0);  // boot ignores inputs
    tbl[18] = mk(0, 0, 0, 0,     32'h04, 32'h04, mw(0),  1);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].t);
      chk($sformatf("vec%0d imem_pc", i), imem_pc, tbl[i].pc);
      chk($sformatf("vec%0d if_id_pc", i), if_id_pc, tbl[i].ipc);
      chk($sformatf("vec%0d if_id_instr", i), if_id_instr, tbl[i].instr);
      chk($sformatf("vec%0d if_id_valid", i), 32'(if_id_valid), 32'(tbl[i].v));
    end

    // PC wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap pre pc", imem_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap pc", imem_pc, 32'h0);
    chk("wrap if_id_pc", if_id_pc, 32'h0);
    chk("wrap instr", if_id_instr, mw(63));
    chk("wrap valid", 32'(if_id_valid), 32'd1);

    // Reset mid-run with freeze asserted
    cyc(0, 0, 1, 32'h3C);
    cyc(0, 0, 0, 0);
    chk("mid pc40", imem_pc, 32'h40);
    cyc(1, 1, 0, 0);
    chk("midrst pc", imem_pc, 32'h0);
    chk("midrst valid", 32'(if_id_valid), 32'd0);
    cyc(0, 1, 1, 32'h80);
    chk("midrst boot pc", imem_pc, 32'h0);
    cyc(0, 0, 0, 0);
    chk("midrst run pc", imem_pc, 32'h4);
    chk("midrst run instr", if_id_instr, mw(0));

    // Self-jump program at 0xE4
    cyc(0, 0, 1, 32'hE4);
    chk("halt pre pc", imem_pc, 32'hE4);
    cyc(0, 0, 0, 0);
    chk("halt jmp latched", if_id_instr, JMP);
    chk("halt jmp valid", 32'(if_id_valid), 32'd1);
    chk("halt pc E8", imem_pc, 32'hE8);
    chk("halt flag", 32'(halted), 32'(HALT_EN));
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("halt hold pc", imem_pc, HALT_EN ? 32'hE8 : 32'hEC);
    chk("halt hold valid", 32'(if_id_valid), HALT_EN ? 32'd0 : 32'd1);
    chk("halt hold instr", if_id_instr, HALT_EN ? 32'h0 : mw(58));
    chk("halt hold flag", 32'(halted), 32'(HALT_EN));
    cyc(0, 0, 1, 32'h20);
    chk("unhalt pc", imem_pc, 32'h20);
    chk("unhalt flag", 32'(halted), 32'd0);
    chk("unhalt valid", 32'(if_id_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[57] = JMP;
    mem[10] = JMP;
    for (int i = 0; i < 1500; i++) begin
      logic        r, f, b;
      logic [31:0] t;
      r = ($urandom_range(31) == 0);
      f = ($urandom_range(3) == 0);
      b = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       t = $urandom;
        1:       t = 32'hE4;
        default: t = 32'($urandom_range(255));
      endcase
      cyc(r, f, b, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
